tug_referee: RTL

Match controller for the tug-of-war playfield. It sits between the two player keys and the row of playfield lights. It edge-detects the keys into one-cycle press pulses for the lights, detects when a point is scored off either end, and drives the playfield's active-high reset between points. It also keeps both players' scores and ends the match at a target score.

---
 rtl/tug_referee.sv | 113 +++++++++++
 1 files changed

// File: rtl/tug_referee.sv
// Tug-of-war match controller: key edge detection, point detection, playfield
// reset hold between points, score keeping and match-end detection.
module tug_referee #(
  parameter int N_LIGHTS    = 9,
  parameter int HOLD_CYCLES = 4,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 3
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                leftKey,
  input  logic                rightKey,
  input  logic [N_LIGHTS-1:0] lights,
  output logic                leftPress,
  output logic                rightPress,
  output logic                fieldReset,
  output logic [SCORE_W-1:0]  leftScore,
  output logic [SCORE_W-1:0]  rightScore,
  output logic                leftWins,
  output logic                rightWins,
  output logic                busy
);

  typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               lkey_q, rkey_q;
  logic               rise_l, rise_r;
  logic [SCORE_W-1:0] left_next, right_next;
  logic               unused_lights;

  assign rise_l        = leftKey & ~lkey_q;
  assign rise_r        = rightKey & ~rkey_q;
  assign left_next     = leftScore + SCORE_W'(1);
  assign right_next    = rightScore + SCORE_W'(1);
  assign unused_lights = ^lights;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state      <= HOLD;
      cnt        <= CNT_INIT;
      lkey_q     <= 1'b1;
      rkey_q     <= 1'b1;
      leftPress  <= 1'b0;
      rightPress <= 1'b0;
      fieldReset <= 1'b1;
      leftScore  <= '0;
      rightScore <= '0;
      leftWins   <= 1'b0;
      rightWins  <= 1'b0;
      busy       <= 1'b1;
    end else begin
      lkey_q     <= leftKey;
      rkey_q     <= rightKey;
      leftPress  <= 1'b0;
      rightPress <= 1'b0;
      case (state)
        PLAY: begin
          // A scoring pulse leaves PLAY, so any edge seen this cycle is dropped.
          if (leftPress && lights[N_LIGHTS-1]) begin
            leftScore  <= left_next;
            fieldReset <= 1'b1;
            busy       <= 1'b1;
            if (left_next == WIN) begin
              state    <= OVER;
              leftWins <= 1'b1;
            end else begin
              state <= HOLD;
              cnt   <= CNT_INIT;
            end
          end else if (rightPress && lights[0]) begin
            rightScore <= right_next;
            fieldReset <= 1'b1;
            busy       <= 1'b1;
            if (right_next == WIN) begin
              state     <= OVER;
              rightWins <= 1'b1;
            end else begin
              state <= HOLD;
              cnt   <= CNT_INIT;
            end
          end else begin
            leftPress  <= rise_l & ~rise_r;
            rightPress <= rise_r & ~rise_l;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state      <= PLAY;
            fieldReset <= 1'b0;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OVER: begin
        end
        default: begin
          state      <= HOLD;
          cnt        <= CNT_INIT;
          fieldReset <= 1'b1;
          busy       <= 1'b1;
        end
      endcase
    end
  end

endmodule
